// File: rtl/trigger_capture.sv
// Multi-channel triggered waveform capture: circular ring per channel, edge/force trigger,
// pre-trigger retention, and a blanking-gated copy of the aligned record into a display buffer.
module trigger_capture #(
    parameter  int DATA_W      = 12,
    parameter  int DEPTH       = 256,
    parameter  int CHANNELS    = 2,
    parameter  int HV_W        = 11,
    parameter  int SAFE_HCOUNT = 600,
    parameter  int SAFE_VLINES = 6,
    localparam int AW          = $clog2(DEPTH),
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    input  logic [CHANNELS*DATA_W-1:0] sample_data,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [1:0]                 mode,
    input  logic [CW-1:0]              trig_ch,
    input  logic [DATA_W-1:0]          trig_level,
    input  logic [AW-1:0]              pre_trig,
    input  logic [HV_W-1:0]            hcount,
    input  logic [HV_W-1:0]            vcount,
    input  logic [CW-1:0]              rd_ch,
    input  logic [AW-1:0]              rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       ready,
    output logic                       triggered,
    output logic                       snapshot_valid
);

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, WAIT_SAFE, COPY} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t                            state, state_nx;
    logic [1:0]                        mode_q;
    logic [CW-1:0]                     ch_q;
    logic [DATA_W-1:0]                 level_q;
    logic [AW-1:0]                     pre_q;
    logic [AW-1:0]                     wr_ptr, trig_ptr, cnt, cnt_inc, post_len, copy_idx;
    logic [CHANNELS*DATA_W-1:0]        prev_bus;
    logic [DATA_W-1:0]                 cur, prv;
    logic                              rise, fall, edge_hit, trig_hit, wr_en, safe;
    logic [CHANNELS-1:0][DATA_W-1:0]   disp_out;

    assign cnt_inc  = cnt + AW'(1);
    assign post_len = LAST - pre_q;
    assign copy_idx = trig_ptr - pre_q + cnt;
    assign safe     = (hcount == HV_W'(SAFE_HCOUNT)) || (vcount < HV_W'(SAFE_VLINES));
    assign wr_en    = sample_valid && (state == PRE || state == ARMED || state == POST);
    assign ready    = (state == IDLE);

    // Previous sample is kept for every channel so the latched source always has history.
    assign cur = sample_data[int'(ch_q)*DATA_W +: DATA_W];
    assign prv = prev_bus[int'(ch_q)*DATA_W +: DATA_W];

    always_comb begin
        rise = (prv < level_q) && (cur >= level_q);
        fall = (prv >= level_q) && (cur < level_q);
        case (mode_q)
            2'd0:    edge_hit = rise;
            2'd1:    edge_hit = fall;
            2'd2:    edge_hit = rise | fall;
            default: edge_hit = 1'b1;
        endcase
    end

    assign trig_hit = sample_valid && !abort && (state == ARMED) && edge_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (arm && !abort) state_nx = (pre_trig == '0) ? ARMED : PRE;
            PRE:       if (sample_valid && cnt_inc == pre_q) state_nx = ARMED;
            ARMED:     if (trig_hit) state_nx = (pre_q == LAST) ? WAIT_SAFE : POST;
            POST:      if (sample_valid && cnt_inc == post_len) state_nx = WAIT_SAFE;
            WAIT_SAFE: if (safe) state_nx = COPY;
            COPY:      if (cnt == LAST) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (abort && (state == PRE || state == ARMED || state == POST || state == WAIT_SAFE))
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q         <= '0;
            ch_q           <= '0;
            level_q        <= '0;
            pre_q          <= '0;
            wr_ptr         <= '0;
            trig_ptr       <= '0;
            cnt            <= '0;
            prev_bus       <= '0;
            triggered      <= 1'b0;
            snapshot_valid <= 1'b0;
            rd_data        <= '0;
        end else begin
            triggered <= trig_hit;
            rd_data   <= disp_out[rd_ch];
            if (sample_valid && state != WAIT_SAFE && state != COPY) prev_bus <= sample_data;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            case (state)
                IDLE: if (arm && !abort) begin
                    mode_q  <= mode;
                    ch_q    <= trig_ch;
                    level_q <= trig_level;
                    pre_q   <= pre_trig;
                    cnt     <= '0;
                end
                PRE:   if (sample_valid) cnt <= (cnt_inc == pre_q) ? '0 : cnt_inc;
                ARMED: if (trig_hit) begin
                    trig_ptr <= wr_ptr;
                    cnt      <= '0;
                end
                POST:  if (sample_valid) cnt <= cnt_inc;
                WAIT_SAFE: if (safe && !abort) begin
                    cnt            <= '0;
                    snapshot_valid <= 1'b0;
                end
                COPY: begin
                    cnt <= cnt_inc;
                    if (cnt == LAST) snapshot_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sample storage is not reset; contents are only meaningful once a record completes.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_W-1:0] ring [DEPTH];
        logic [DATA_W-1:0] disp [DEPTH];
        always_ff @(posedge clk) begin
            if (wr_en)          ring[wr_ptr] <= sample_data[c*DATA_W +: DATA_W];
            if (state == COPY)  disp[cnt]    <= ring[copy_idx];
        end
        assign disp_out[c] = disp[rd_addr];
    end

endmodule
